bldc_sensor_emulator: RTL



---
 rtl/bldc_sensor_emulator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bldc_sensor_emulator.sv
// Sensor-side stand-in for a BLDC motor: emits a six-step hall ring and a quadrature
// encoder at a commanded edge rate and checks the drive's gate pattern against the hall state.
module bldc_sensor_emulator #(
   parameter int PERIOD_WIDTH    = 16,
   parameter int EDGES_PER_HALL  = 8,
   parameter int GRACE_CYCLES    = 40,
   parameter int ERR_COUNT_WIDTH = 16,
   parameter int POS_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [PERIOD_WIDTH-1:0]    edge_period,
   input  logic                       reverse,
   input  logic                       hall_disconnect,
   input  logic                       check_en,
   input  logic                       clear_faults,
   input  logic [2:0]                 phaseH,
   input  logic [2:0]                 phaseL,
   output logic [2:0]                 hall,
   output logic [1:0]                 enc,
   output logic [POS_WIDTH-1:0]       position,
   output logic                       shoot_through,
   output logic [ERR_COUNT_WIDTH-1:0] commutation_errors
);

   localparam int SUB_W   = $clog2(EDGES_PER_HALL);
   localparam int GRACE_W = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;

   localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = PERIOD_WIDTH'(1);
   localparam logic [POS_WIDTH-1:0]    POS_ONE  = POS_WIDTH'(1);
   localparam logic [SUB_W-1:0]        SUB_ONE  = SUB_W'(1);
   localparam logic [SUB_W-1:0]        SUB_LAST = SUB_W'(EDGES_PER_HALL - 1);
   localparam logic [GRACE_W-1:0]      GRACE_LD = GRACE_W'(GRACE_CYCLES);
   localparam logic [GRACE_W-1:0]      GRACE_ONE = GRACE_W'(1);
   localparam logic [ERR_COUNT_WIDTH-1:0] ERR_ONE = ERR_COUNT_WIDTH'(1);

   logic [PERIOD_WIDTH-1:0] presc;
   logic [SUB_W-1:0]        sub_cnt, sub_nxt;
   logic [2:0]              hall_idx, hall_nxt;
   logic [1:0]              enc_idx, enc_nxt;
   logic [POS_WIDTH-1:0]    pos_nxt;
   logic                    dir_q, dir_nxt;
   logic [GRACE_W-1:0]      grace;

   logic       edge_strobe;
   logic       hall_step, dir_flip;
   logic [2:0] drive_h, drive_l, exp_h, exp_l;
   logic       mismatch, shoot_hit;

   function automatic logic [2:0] hall_code(input logic [2:0] idx);
      case (idx)
         3'd0:    hall_code = 3'b101;
         3'd1:    hall_code = 3'b100;
         3'd2:    hall_code = 3'b110;
         3'd3:    hall_code = 3'b010;
         3'd4:    hall_code = 3'b011;
         3'd5:    hall_code = 3'b001;
         default: hall_code = 3'b101;
      endcase
   endfunction

   // Ring index to {B, A}: 00, 01, 11, 10 is a Gray walk.
   function automatic logic [1:0] enc_code(input logic [1:0] idx);
      enc_code = {idx[1], idx[1] ^ idx[0]};
   endfunction

   // A period cut below the current count fires on the very next clock.
   assign edge_strobe = (edge_period != '0) && (presc >= edge_period - PER_ONE);

   // Next-state logic: hall index, sub-counter, encoder ring and position move together.
   always_comb begin
      sub_nxt  = sub_cnt;
      hall_nxt = hall_idx;
      enc_nxt  = enc_idx;
      pos_nxt  = position;
      dir_nxt  = dir_q;
      if (edge_strobe) begin
         dir_nxt = reverse;
         if (!reverse) begin
            enc_nxt = enc_idx + 2'd1;
            pos_nxt = position + POS_ONE;
            if (sub_cnt == SUB_LAST) begin
               sub_nxt  = '0;
               hall_nxt = (hall_idx == 3'd5) ? 3'd0 : hall_idx + 3'd1;
            end else begin
               sub_nxt = sub_cnt + SUB_ONE;
            end
         end else begin
            enc_nxt = enc_idx - 2'd1;
            pos_nxt = position - POS_ONE;
            if (sub_cnt == '0) begin
               sub_nxt  = SUB_LAST;
               hall_nxt = (hall_idx == 3'd0) ? 3'd5 : hall_idx - 3'd1;
            end else begin
               sub_nxt = sub_cnt - SUB_ONE;
            end
         end
      end
   end

   assign hall_step = (hall_nxt != hall_idx);
   assign dir_flip  = (dir_nxt != dir_q);

   // Output/decision logic: expected gate phases for the current internal hall step.
   always_comb begin
      drive_h = 3'b000;
      drive_l = 3'b000;
      case (hall_idx)
         3'd0: begin drive_h = 3'b001; drive_l = 3'b010; end
         3'd1: begin drive_h = 3'b001; drive_l = 3'b100; end
         3'd2: begin drive_h = 3'b010; drive_l = 3'b100; end
         3'd3: begin drive_h = 3'b010; drive_l = 3'b001; end
         3'd4: begin drive_h = 3'b100; drive_l = 3'b001; end
         3'd5: begin drive_h = 3'b100; drive_l = 3'b010; end
         default: begin drive_h = 3'b000; drive_l = 3'b000; end
      endcase
      exp_h     = dir_q ? drive_l : drive_h;
      exp_l     = dir_q ? drive_h : drive_l;
      mismatch  = check_en && (grace == '0) &&
                  (((phaseH & ~exp_h) != 3'b000) || ((phaseL & ~exp_l) != 3'b000));
      shoot_hit = check_en && ((phaseH & phaseL) != 3'b000);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc              <= '0;
         sub_cnt            <= '0;
         hall_idx           <= 3'd0;
         enc_idx            <= 2'd0;
         dir_q              <= 1'b0;
         grace              <= GRACE_LD;
         hall               <= 3'b101;
         enc                <= 2'b00;
         position           <= '0;
         shoot_through      <= 1'b0;
         commutation_errors <= '0;
      end else begin
         if (edge_strobe || (edge_period == '0)) presc <= '0;
         else                                   presc <= presc + PER_ONE;

         sub_cnt  <= sub_nxt;
         hall_idx <= hall_nxt;
         enc_idx  <= enc_nxt;
         dir_q    <= dir_nxt;
         position <= pos_nxt;
         enc      <= enc_code(enc_nxt);
         // Disconnect only masks the pins; the ring keeps turning underneath.
         hall     <= hall_disconnect ? 3'b111 : hall_code(hall_nxt);

         if (hall_step || dir_flip) grace <= GRACE_LD;
         else if (grace != '0)      grace <= grace - GRACE_ONE;

         if (clear_faults)   shoot_through <= 1'b0;
         else if (shoot_hit) shoot_through <= 1'b1;

         if (clear_faults)
            commutation_errors <= '0;
         else if (mismatch && (commutation_errors != '1))
            commutation_errors <= commutation_errors + ERR_ONE;
      end
   end

endmodule
